// File: rtl/cpu_state_sequencer.sv
// Multicycle FETCH/DECODE/EXEC1/EXEC2 sequencer with bus/multdiv stall handling,
// program halt and a stall watchdog. Optional counters under SEQ_PERF_COUNTERS_EN.
module cpu_state_sequencer #(
  parameter int STATE_W        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               waitrequest,
  input  logic               mem_rd_exec1,
  input  logic               multdiv_busy,
  input  logic               halt_req,
  output logic [STATE_W-1:0] state,
  output logic               active,
  output logic               retire,
  output logic               stall,
  output logic               bus_fault
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count
`endif
);

  localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_EXEC1  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_EXEC2  = STATE_W'(4);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               hold_exec1;
  logic               wd_expire;

  // multdiv_busy alone is enough to hold EXEC1, even once the load has completed.
  assign hold_exec1 = (mem_rd_exec1 & waitrequest) | multdiv_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = waitrequest ? S_FETCH : S_DECODE;
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1:  state_d = hold_exec1 ? S_EXEC1 : S_EXEC2;
      S_EXEC2:  state_d = waitrequest ? S_EXEC2 : (halt_req ? S_HALT : S_FETCH);
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    if (wd_expire) state_d = S_HALT;
  end

  always_comb begin
    stall  = 1'b0;
    retire = 1'b0;
    case (state_q)
      S_FETCH: stall = waitrequest;
      S_EXEC1: stall = hold_exec1;
      S_EXEC2: begin
        stall  = waitrequest;
        retire = ~waitrequest;
      end
      default: begin
        stall  = 1'b0;
        retire = 1'b0;
      end
    endcase
  end

  assign state  = state_q;
  assign active = (state_q != S_HALT);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      logic [CNT_W-1:0] wd_cnt;
      logic             fault_q;

      // Counts consecutive stall cycles; holding at WD_LAST keeps it from wrapping.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wd_cnt  <= '0;
          fault_q <= 1'b0;
        end else begin
          if (!stall)                wd_cnt <= '0;
          else if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + 1'b1;
          if (wd_expire) fault_q <= 1'b1;
        end
      end

      assign wd_expire = stall && (wd_cnt == WD_LAST);
      assign bus_fault = fault_q;
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
      assign bus_fault = 1'b0;
    end
  endgenerate

`ifdef SEQ_PERF_COUNTERS_EN
  // Both counters stop in HALT because active and retire are low there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (active) cycle_count <= cycle_count + 1'b1;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Randomized bench for cpu_state_sequencer against an instruction-phase reference model.
// Watchdog exercised with a short timeout; counters checked when SEQ_PERF_COUNTERS_EN is set.
module tb_cpu_state_sequencer;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 32;
  localparam int HALT = 0, FETCH = 1, DECODE = 2, EXEC1 = 3, EXEC2 = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic waitrequest = 1'b0;
  logic mem_rd_exec1 = 1'b0;
  logic multdiv_busy = 1'b0;
  logic halt_req = 1'b0;
  logic [3:0] state;
  logic active, retire, stall, bus_fault;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_count, instr_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  // reference model: current phase, consecutive-stall run, sticky fault, counters
  int          m_state;
  int          m_run;
  bit          m_fault;
  logic [31:0] m_cyc, m_ins;

  always #5 clk = ~clk;

  cpu_state_sequencer #(
    .STATE_W(4), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest),
    .mem_rd_exec1(mem_rd_exec1), .multdiv_busy(multdiv_busy), .halt_req(halt_req),
    .state(state), .active(active), .retire(retire), .stall(stall),
    .bus_fault(bus_fault)
`ifdef SEQ_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves at the following negedge with reset released.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), FETCH);
    check("rst_active", 32'(active), 1);
    check("rst_fault", 32'(bus_fault), 0);
`ifdef SEQ_PERF_COUNTERS_EN
    check("rst_cyc", cycle_count, 0);
    check("rst_ins", instr_count, 0);
`endif
    m_state = FETCH;
    m_run   = 0;
    m_fault = 0;
    m_cyc   = '0;
    m_ins   = '0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check state.
  task automatic cycle(input bit wr, input bit mrd, input bit mdb, input bit hr);
    bit stl = 0;
    bit ret = 0;
    int nxt;
    logic [3:0] exp_state;
    waitrequest  = wr;
    mem_rd_exec1 = mrd;
    multdiv_busy = mdb;
    halt_req     = hr;
    #1;
    case (m_state)
      FETCH:  begin stl = wr; nxt = wr ? FETCH : DECODE; end
      DECODE: nxt = EXEC1;
      EXEC1:  begin stl = mdb || (mrd && wr); nxt = stl ? EXEC1 : EXEC2; end
      EXEC2:  begin stl = wr; ret = !wr; nxt = wr ? EXEC2 : (hr ? HALT : FETCH); end
      default: nxt = HALT;
    endcase
    check("active", 32'(active), (m_state != HALT) ? 1 : 0);
    check("stall", 32'(stall), 32'(stl));
    check("retire", 32'(retire), 32'(ret));
    check("bus_fault", 32'(bus_fault), 32'(m_fault));
`ifdef SEQ_PERF_COUNTERS_EN
    check("cycle_count", cycle_count, m_cyc);
    check("instr_count", instr_count, m_ins);
`endif
    // the TIMEOUT-th consecutive stall cycle ends in HALT with a sticky fault
    if (stl) begin
      m_run++;
      if (m_run == TIMEOUT) begin
        nxt = HALT;
        m_fault = 1;
      end
    end else begin
      m_run = 0;
    end
    if (m_state != HALT) m_cyc = m_cyc + 1;
    if (ret) m_ins = m_ins + 1;
    m_state = nxt;
    exp_q.push_back(4'(nxt));
    @(posedge clk);
    #1;
    exp_state = exp_q.pop_front();
    check("state", 32'(state), 32'(exp_state));
    @(negedge clk);
  endtask

  initial begin
    int stuck;
    int halt_wait;
    bit wr;
    @(negedge clk);

    // three stall-free instructions, the third halting
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, i == 11);
    check("nostall_halt", 32'(state), HALT);
`ifdef SEQ_PERF_COUNTERS_EN
    check("perf_cyc12", cycle_count, 12);
    check("perf_ins3", instr_count, 3);
    for (int i = 0; i < 4; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
    check("perf_cyc_frozen", cycle_count, 12);
    check("perf_ins_frozen", instr_count, 3);
`endif

    // fetch stall of three cycles, then a full instruction
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("fetch_held", 32'(state), FETCH);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("fetch_next_instr", 32'(state), FETCH);

    // load overlapping a multiply/divide in EXEC1
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(i < 2, 1'b1, 1'b1, 1'b0);
    check("exec1_held", 32'(state), EXEC1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("exec1_exit", 32'(state), EXEC2);

    // halt request while EXEC2 is still stalled
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("exec2_held", 32'(state), EXEC2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("halt_state", 32'(state), HALT);
    check("halt_active", 32'(active), 0);
    for (int i = 0; i < 20; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("halt_persist", 32'(state), HALT);

    // watchdog: waitrequest stuck in FETCH
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("wd_state", 32'(state), HALT);
    check("wd_fault", 32'(bus_fault), 1);
    for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    check("wd_fault_sticky", 32'(bus_fault), 1);
    do_reset();

    // randomized traffic with occasional stuck bus and resets
    stuck = 0;
    halt_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      if (stuck == 0 && $urandom_range(0, 59) == 0) stuck = $urandom_range(1, 12);
      if (stuck > 0) begin
        wr = 1'b1;
        stuck--;
      end else begin
        wr = ($urandom_range(0, 9) < 4);
      end
      cycle(wr, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
      if (m_state == HALT) halt_wait++;
      if (halt_wait > 3 || $urandom_range(0, 399) == 0) begin
        do_reset();
        halt_wait = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
